ln_range_reducer: RTL and testbench

//  Upstream stage of the natural-log datapath. Decomposes an IEEE-754 single X = 2^k * (1+T)

---
 rtl/ln_range_reducer.sv | 186 ++++++++++++++++++
 tb/tb_ln_range_reducer.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ln_range_reducer.sv
// Range reduction for the ln datapath: splits binary32 X into k and T, where X = 2^k * (1+T).
// It screens special operands, then clears, launches and waits on the LINEALIZADOR stage.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   S_IDLE    | waiting for Begin_FSM_RR
//   S_DECODE  | classify the latched X; compute k; pick the T path
//   S_NORM    | shift the fraction left until its leading one reaches bit MW
//   S_CLR     | request the clear pulse to LINEALIZADOR
//   S_LAUNCH  | request the start pulse; load the watchdog
//   S_WAIT_LN | wait for ACK_LN or for the watchdog to expire
//   S_DONE    | results held, ACK_RR high; a new start is accepted
module ln_range_reducer #(
  parameter int P      = 32,
  parameter int EW     = 8,
  parameter int MW     = 23,
  parameter int TO_CYC = 1000
) (
  input  logic          CLK,
  input  logic          RST_RR,
  input  logic          Begin_FSM_RR,
  input  logic [P-1:0]  X,
  output logic          ACK_RR,
  output logic [P-1:0]  T,
  output logic [EW-1:0] EXP_K,
  output logic          RST_LN,
  output logic          Begin_FSM_LN,
  input  logic          ACK_LN,
  output logic          NAN_F,
  output logic          ZERO_F,
  output logic          O_F,
  output logic          TO_F
);

  localparam int NW  = $clog2(MW + 1);
  localparam int WDW = $clog2(TO_CYC + 1);
  localparam logic [EW-1:0] EXP_BIAS = EW'((1 << (EW - 1)) - 1);
  localparam logic [EW-1:0] EXP_MAX  = '1;

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_NORM, S_CLR, S_LAUNCH, S_WAIT_LN, S_DONE
  } state_t;

  state_t state_q, state_nxt;
  logic [P-1:0]   x_q, x_nxt;
  logic [MW:0]    sh_q, sh_nxt;
  logic [NW-1:0]  n_q, n_nxt;
  logic [WDW-1:0] wd_q, wd_nxt;
  logic [P-1:0]   t_q, t_nxt;
  logic [EW-1:0]  k_q, k_nxt;
  logic           nan_q, nan_nxt, zero_q, zero_nxt, ovf_q, ovf_nxt, to_q, to_nxt;
  logic           rst_ln_q, rst_ln_nxt, beg_ln_q, beg_ln_nxt;

  logic           x_sign;
  logic [EW-1:0]  x_exp;
  logic [MW-1:0]  x_frac;

  assign x_sign = x_q[P-1];
  assign x_exp  = x_q[P-2:MW];
  assign x_frac = x_q[MW-1:0];

  always_ff @(posedge CLK) begin
    if (!RST_RR) begin
      state_q  <= S_IDLE;
      x_q      <= '0;
      sh_q     <= '0;
      n_q      <= '0;
      wd_q     <= '0;
      t_q      <= '0;
      k_q      <= '0;
      nan_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      to_q     <= 1'b0;
      rst_ln_q <= 1'b0;
      beg_ln_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      x_q      <= x_nxt;
      sh_q     <= sh_nxt;
      n_q      <= n_nxt;
      wd_q     <= wd_nxt;
      t_q      <= t_nxt;
      k_q      <= k_nxt;
      nan_q    <= nan_nxt;
      zero_q   <= zero_nxt;
      ovf_q    <= ovf_nxt;
      to_q     <= to_nxt;
      rst_ln_q <= rst_ln_nxt;
      beg_ln_q <= beg_ln_nxt;
    end
  end

  always_comb begin
    state_nxt  = state_q;
    x_nxt      = x_q;
    sh_nxt     = sh_q;
    n_nxt      = n_q;
    wd_nxt     = wd_q;
    t_nxt      = t_q;
    k_nxt      = k_q;
    nan_nxt    = nan_q;
    zero_nxt   = zero_q;
    ovf_nxt    = ovf_q;
    to_nxt     = to_q;
    rst_ln_nxt = 1'b0;
    beg_ln_nxt = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (Begin_FSM_RR) begin
          x_nxt     = X;
          t_nxt     = '0;
          k_nxt     = '0;
          nan_nxt   = 1'b0;
          zero_nxt  = 1'b0;
          ovf_nxt   = 1'b0;
          to_nxt    = 1'b0;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = S_DONE;
        if (x_exp == EXP_MAX) begin
          if (x_frac != '0 || x_sign) nan_nxt = 1'b1;
          else                        ovf_nxt = 1'b1;
        end else if (x_exp == '0) begin
          zero_nxt = 1'b1;
        end else if (x_sign) begin
          nan_nxt = 1'b1;
        end else begin
          k_nxt = x_exp - EXP_BIAS;
          if (x_frac == '0) begin
            t_nxt     = '0;
            state_nxt = S_CLR;
          end else begin
            sh_nxt    = {1'b0, x_frac};
            n_nxt     = '0;
            state_nxt = S_NORM;
          end
        end
      end
      S_NORM: begin
        // Once the leading one sits in the hidden-bit slot, n is the exponent offset of T.
        if (sh_q[MW]) begin
          t_nxt     = {1'b0, EXP_BIAS - EW'(n_q), sh_q[MW-1:0]};
          state_nxt = S_CLR;
        end else begin
          sh_nxt = {sh_q[MW-1:0], 1'b0};
          n_nxt  = n_q + NW'(1);
        end
      end
      S_CLR: begin
        rst_ln_nxt = 1'b1;
        state_nxt  = S_LAUNCH;
      end
      S_LAUNCH: begin
        beg_ln_nxt = 1'b1;
        wd_nxt     = WDW'(TO_CYC - 1);
        state_nxt  = S_WAIT_LN;
      end
      S_WAIT_LN: begin
        // An acknowledge on the last watchdog cycle still wins over the timeout.
        if (ACK_LN) begin
          state_nxt = S_DONE;
        end else if (wd_q == '0) begin
          to_nxt    = 1'b1;
          state_nxt = S_DONE;
        end else begin
          wd_nxt = wd_q - WDW'(1);
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign ACK_RR       = (state_q == S_DONE);
  assign T            = t_q;
  assign EXP_K        = k_q;
  assign RST_LN       = rst_ln_q;
  assign Begin_FSM_LN = beg_ln_q;
  assign NAN_F        = nan_q;
  assign ZERO_F       = zero_q;
  assign O_F          = ovf_q;
  assign TO_F         = to_q;

endmodule

// File: tb/tb_ln_range_reducer.sv
// Scoreboard bench for ln_range_reducer: the expected decomposition is queued at start and
// checked when ACK_RR rises, with a small LINEALIZADOR responder driving ACK_LN.
module tb_ln_range_reducer;

  localparam int TO_CYC = 1000;

  logic        CLK = 1'b0;
  logic        RST_RR = 1'b0;
  logic        Begin_FSM_RR = 1'b0;
  logic [31:0] X = '0;
  logic        ACK_RR;
  logic [31:0] T;
  logic [7:0]  EXP_K;
  logic        RST_LN;
  logic        Begin_FSM_LN;
  logic        ACK_LN = 1'b0;
  logic        NAN_F, ZERO_F, O_F, TO_F;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] t;
    logic [7:0]  k;
    logic [3:0]  flags;   // {NAN, ZERO, O, TO}
    int          lat;     // cycles to Begin_FSM_LN, or to ACK_RR on special paths
    bit          launch;
  } exp_t;

  exp_t sb[$];

  ln_range_reducer #(.P(32), .EW(8), .MW(23), .TO_CYC(TO_CYC)) dut (
    .CLK(CLK), .RST_RR(RST_RR), .Begin_FSM_RR(Begin_FSM_RR), .X(X),
    .ACK_RR(ACK_RR), .T(T), .EXP_K(EXP_K), .RST_LN(RST_LN),
    .Begin_FSM_LN(Begin_FSM_LN), .ACK_LN(ACK_LN),
    .NAN_F(NAN_F), .ZERO_F(ZERO_F), .O_F(O_F), .TO_F(TO_F)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] x, input bit no_ack);
    exp_t m;
    logic [7:0]  e;
    logic [22:0] f;
    logic [22:0] mant;
    int lo, n;
    e = x[30:23];
    f = x[22:0];
    m.t = '0; m.k = '0; m.flags = '0; m.lat = 2; m.launch = 0;
    if (e == 8'hFF)      m.flags = (f != 0 || x[31]) ? 4'b1000 : 4'b0010;
    else if (e == 8'h00) m.flags = 4'b0100;
    else if (x[31])      m.flags = 4'b1000;
    else begin
      m.launch = 1;
      m.k = e - 8'd127;
      if (f == 0) m.lat = 4;
      else begin
        lo = 22;
        while (!f[lo]) lo--;
        n = 23 - lo;
        mant = f << n;
        m.t = {1'b0, 8'(127 - n), mant};
        m.lat = 5 + n;
      end
      if (no_ack) m.flags = 4'b0001;
    end
    return m;
  endfunction

  function automatic logic [63:0] all_outs();
    return {17'd0, ACK_RR, T, EXP_K, RST_LN, Begin_FSM_LN, NAN_F, ZERO_F, O_F, TO_F};
  endfunction

  task automatic run_op(input logic [31:0] x, input int ack_dly, input bit no_ack);
    exp_t e;
    int cyc, beg_cyc, n_beg, n_rst;
    bit done;
    sb.push_back(model(x, no_ack));
    X = x;
    Begin_FSM_RR = 1'b1;
    @(posedge CLK); #1;
    Begin_FSM_RR = 1'b0;
    cyc = 1; beg_cyc = 0; n_beg = 0; n_rst = 0; done = 0;
    while (!done && cyc < 3000) begin
      if (RST_LN) n_rst++;
      if (Begin_FSM_LN) begin n_beg++; beg_cyc = cyc; end
      ACK_LN = (!no_ack && n_beg > 0 && cyc == beg_cyc + ack_dly);
      if (ACK_RR) done = 1;
      else begin @(posedge CLK); #1; cyc++; end
    end
    ACK_LN = 1'b0;
    chk($sformatf("done_%h", x), done, 1);
    e = sb.pop_front();
    chk($sformatf("T_%h", x), T, e.t);
    chk($sformatf("EXP_K_%h", x), EXP_K, e.k);
    chk($sformatf("flags_%h", x), {NAN_F, ZERO_F, O_F, TO_F}, e.flags);
    chk($sformatf("rst_ln_pulses_%h", x), n_rst, e.launch ? 1 : 0);
    chk($sformatf("beg_ln_pulses_%h", x), n_beg, e.launch ? 1 : 0);
    if (e.launch) chk($sformatf("beg_latency_%h", x), beg_cyc, e.lat);
    else          chk($sformatf("done_latency_%h", x), cyc, e.lat);
    if (no_ack)   chk($sformatf("timeout_cycles_%h", x), cyc - beg_cyc, TO_CYC);
    // idle a cycle in DONE so the result hold is also exercised
    @(posedge CLK); #1;
    chk($sformatf("hold_%h", x), {ACK_RR, T, EXP_K}, {1'b1, e.t, e.k});
  endtask

  task automatic start_only(input logic [31:0] x);
    X = x;
    Begin_FSM_RR = 1'b1;
    @(posedge CLK); #1;
    Begin_FSM_RR = 1'b0;
  endtask

  initial begin
    bit seen;
    RST_RR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_outs", all_outs(), 64'd0);
    RST_RR = 1'b1;
    @(posedge CLK); #1;

    run_op(32'h3FC00000, 2, 0);
    run_op(32'h40400000, 0, 0);
    run_op(32'h3E800000, 3, 0);
    run_op(32'h3F800001, 1, 0);
    run_op(32'h3F800000, 5, 0);
    run_op(32'hC0000000, 1, 0);
    run_op(32'h7FC00000, 1, 0);
    run_op(32'h00000000, 1, 0);
    run_op(32'h00000001, 1, 0);
    run_op(32'h7F800000, 1, 0);
    run_op(32'hFF800000, 1, 0);
    run_op(32'h80000000, 1, 0);
    run_op(32'h7F7FFFFF, 2, 0);
    run_op(32'h00800000, 2, 0);
    run_op(32'h3FC00000, 0, 1);
    run_op(32'h40490FDB, 4, 0);
    for (int i = 0; i < 6; i++)
      run_op({1'b0, 8'($urandom_range(1, 254)), 23'($urandom)}, int'($urandom_range(0, 4)), 0);

    // synchronous reset while normalising a long fraction
    start_only(32'h3F800001);
    repeat (4) @(posedge CLK);
    #1;
    RST_RR = 1'b0;
    @(posedge CLK); #1;
    chk("reset_in_norm", all_outs(), 64'd0);
    RST_RR = 1'b1;
    run_op(32'h40400000, 1, 0);

    // synchronous reset while waiting on LINEALIZADOR
    start_only(32'h3F800000);
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      @(posedge CLK); #1;
      if (Begin_FSM_LN) seen = 1;
    end
    chk("wait_reached", seen, 1);
    repeat (3) @(posedge CLK);
    #1;
    RST_RR = 1'b0;
    @(posedge CLK); #1;
    chk("reset_in_wait", all_outs(), 64'd0);
    RST_RR = 1'b1;
    run_op(32'h3FC00000, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
